// File: rtl/rr_arbiter16_pkg.sv
// Shared constants for the round-robin arbiter and the pipeline controllers.
// Contents: requester count, index width, reset mask value, FSM encodings.
package rr_arbiter16_pkg;

  localparam int unsigned N_REQ_DEF  = 16;
  localparam int unsigned IDX_W      = 4;
  localparam logic [15:0] MASK_RESET = 16'hFFFF;

  // FSM encodings kept as plain constants for the legacy controllers
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/rr_arbiter16_if.sv
// Request/grant/mask bundle for rr_arbiter16.
//   req        : per-requester request lines
//   mask_we    : enable-mask write strobe
//   mask_wdata : new enable-mask value
//   gnt_ready  : shared resource accepts the current grant
//   gnt_valid  : grant offered
//   gnt_idx    : binary index of granted requester
//   gnt_onehot : one-hot grant, zero when no grant
//   mask       : current enable mask
// master = requester/resource side, slave = arbiter side.
interface rr_arbiter16_if;
  import rr_arbiter16_pkg::*;

  logic [N_REQ_DEF-1:0] req;
  logic                 mask_we;
  logic [N_REQ_DEF-1:0] mask_wdata;
  logic                 gnt_ready;
  logic                 gnt_valid;
  logic [IDX_W-1:0]     gnt_idx;
  logic [N_REQ_DEF-1:0] gnt_onehot;
  logic [N_REQ_DEF-1:0] mask;

  modport master (
    output req, mask_we, mask_wdata, gnt_ready,
    input  gnt_valid, gnt_idx, gnt_onehot, mask
  );

  modport slave (
    input  req, mask_we, mask_wdata, gnt_ready,
    output gnt_valid, gnt_idx, gnt_onehot, mask
  );

endinterface

// File: rtl/rr_arbiter16_decoder4.sv
// Existing 4-to-16 binary-to-one-hot decoder.
//   a : 4-bit binary index
//   y : 16-bit one-hot output, bit a set
module decoder4 (
  input  logic [3:0]  a,
  output logic [15:0] y
);

  always_comb begin
    y = '0;
    y[a] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with programmable enable mask.
//   clk   : clock, all state updates on rising edge
//   reset : synchronous active-high reset
//   arb   : request/grant/mask bundle (slave side)
// A grant is held until handshake (gnt_valid & gnt_ready); on handshake the
// next grant is chosen in the same cycle starting just past the served index.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF
) (
  input  logic          clk,
  input  logic          reset,
  rr_arbiter16_if.slave arb
);

  logic [0:0]       state;
  logic [IDX_W-1:0] gnt_idx_q;
  logic [IDX_W-1:0] ptr;
  logic [15:0]      mask_q;

  logic [15:0]      eligible;
  logic             handshake;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] search_base;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] sel;
  logic             found;
  logic [15:0]      dec_out;

  assign eligible  = arb.req & mask_q;
  assign handshake = (state == ST_GRANT) && arb.gnt_ready;
  assign next_ptr  = gnt_idx_q + 1'b1;

  // On a handshake the search starts from the pointer value being written
  // this cycle, so back-to-back grants already skip the served requester.
  assign search_base = handshake ? next_ptr : ptr;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = search_base + IDX_W'(i);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      gnt_idx_q <= '0;
      ptr       <= '0;
      mask_q    <= MASK_RESET;
    end else begin
      if (arb.mask_we) begin
        mask_q <= arb.mask_wdata;
      end
      case (state)
        ST_IDLE: begin
          if (found) begin
            gnt_idx_q <= sel;
            state     <= ST_GRANT;
          end
        end
        default: begin
          if (arb.gnt_ready) begin
            ptr <= next_ptr;
            if (found) begin
              gnt_idx_q <= sel;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  decoder4 u_dec (
    .a (gnt_idx_q),
    .y (dec_out)
  );

  assign arb.gnt_valid  = (state == ST_GRANT);
  assign arb.gnt_idx    = gnt_idx_q;
  assign arb.gnt_onehot = dec_out & {16{arb.gnt_valid}};
  assign arb.mask       = mask_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: per-cycle vectors of inputs and
// expected outputs, queued as expectations when driven and compared after
// the clock edge that produces them.
module tb_rr_arbiter16;

  logic clk;
  logic reset;

  rr_arbiter16_if arb ();

  rr_arbiter16 #(.N_REQ(16)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (arb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic        rst;
    logic [15:0] req;
    logic        mwe;
    logic [15:0] mwd;
    logic        rdy;
    logic        ev;
    logic [3:0]  ei;
    logic [15:0] em;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rst, input logic [15:0] rq, input logic mwe,
                     input logic [15:0] mwd, input logic rdy, input logic ev,
                     input logic [3:0] ei, input logic [15:0] em);
    vec_t v;
    v.tag = vecs.size();
    v.rst = rst; v.req = rq; v.mwe = mwe; v.mwd = mwd; v.rdy = rdy;
    v.ev = ev; v.ei = ei; v.em = em;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int tag,
                     input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, tag, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    logic [15:0] exp_oh;
    @(negedge clk);
    reset          = v.rst;
    arb.req        = v.req;
    arb.mask_we    = v.mwe;
    arb.mask_wdata = v.mwd;
    arb.gnt_ready  = v.rdy;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard vec %0d: got empty queue expected entry", v.tag);
    end else begin
      e = exp_q.pop_front();
      exp_oh = e.ev ? (16'h0001 << e.ei) : 16'h0000;
      chk("gnt_valid",  e.tag, {15'h0, arb.gnt_valid}, {15'h0, e.ev});
      chk("gnt_idx",    e.tag, {12'h0, arb.gnt_idx},   {12'h0, e.ei});
      chk("gnt_onehot", e.tag, arb.gnt_onehot,          exp_oh);
      chk("mask",       e.tag, arb.mask,                e.em);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t h;
    reset          = 1'b1;
    arb.req        = '0;
    arb.mask_we    = 1'b0;
    arb.mask_wdata = '0;
    arb.gnt_ready  = 1'b0;

    // reset for two cycles; mask write and ready must be overridden
    add(1, 16'hFFFF, 1, 16'h0000, 1, 0, 4'd0, 16'hFFFF);
    add(1, 16'hFFFF, 1, 16'h0000, 1, 0, 4'd0, 16'hFFFF);
    // idle with no requests
    add(0, 16'h0000, 0, 16'h0000, 1, 0, 4'd0, 16'hFFFF);
    // all requesting, always ready: 0..15,0 back-to-back
    for (int j = 0; j < 17; j++)
      add(0, 16'hFFFF, 0, 16'h0000, 1, 1, 4'(j), 16'hFFFF);
    // wrap: 0 served -> 15, hold, served -> 0, then drop to idle
    add(0, 16'h8001, 0, 16'h0000, 1, 1, 4'd15, 16'hFFFF);
    add(0, 16'h8001, 0, 16'h0000, 0, 1, 4'd15, 16'hFFFF);
    add(0, 16'h8001, 0, 16'h0000, 1, 1, 4'd0,  16'hFFFF);
    add(0, 16'h0000, 0, 16'h0000, 1, 0, 4'd0,  16'hFFFF);
    // grant 3, stall 5 cycles while req changes, then handshake -> 4
    add(0, 16'h0008, 0, 16'h0000, 0, 1, 4'd3, 16'hFFFF);
    add(0, 16'h0010, 0, 16'h0000, 0, 1, 4'd3, 16'hFFFF);
    add(0, 16'h0008, 0, 16'h0000, 0, 1, 4'd3, 16'hFFFF);
    add(0, 16'h0010, 0, 16'h0000, 0, 1, 4'd3, 16'hFFFF);
    add(0, 16'h0010, 0, 16'h0000, 0, 1, 4'd3, 16'hFFFF);
    add(0, 16'h0010, 0, 16'h0000, 0, 1, 4'd3, 16'hFFFF);
    add(0, 16'h0010, 0, 16'h0000, 1, 1, 4'd4, 16'hFFFF);
    add(0, 16'h0000, 0, 16'h0000, 1, 0, 4'd4, 16'hFFFF);
    add(0, 16'h0000, 0, 16'h0000, 1, 0, 4'd4, 16'hFFFF);
    // mask out requester 0: only 1 is granted
    add(0, 16'h0000, 1, 16'hFFFE, 0, 0, 4'd4, 16'hFFFE);
    add(0, 16'h0003, 0, 16'h0000, 1, 1, 4'd1, 16'hFFFE);
    add(0, 16'h0003, 0, 16'h0000, 1, 1, 4'd1, 16'hFFFE);
    add(0, 16'h0003, 0, 16'h0000, 1, 1, 4'd1, 16'hFFFE);
    // re-enable: old mask still governs this edge's arbitration
    add(0, 16'h0003, 1, 16'hFFFF, 1, 1, 4'd1, 16'hFFFF);
    add(0, 16'h0003, 0, 16'h0000, 1, 1, 4'd0, 16'hFFFF);
    add(0, 16'h0003, 0, 16'h0000, 1, 1, 4'd1, 16'hFFFF);
    add(0, 16'h0000, 0, 16'h0000, 1, 0, 4'd1, 16'hFFFF);

    for (int k = 0; k < vecs.size(); k++)
      apply(vecs[k]);

    // reset in the middle of a grant at index 7 (pointer is 2 here)
    h.rst = 0; h.req = 16'hFFFF; h.mwe = 0; h.mwd = 16'h0000; h.rdy = 1;
    h.ev = 1; h.em = 16'hFFFF;
    for (int k = 2; k <= 7; k++) begin
      h.tag = 100 + k;
      h.ei  = 4'(k);
      apply(h);
    end
    h.tag = 110; h.rst = 1; h.mwe = 1; h.mwd = 16'h0000;
    h.ev = 0; h.ei = 4'd0;
    apply(h);
    h.tag = 111; h.rst = 0; h.mwe = 0; h.rdy = 0; h.ev = 1; h.ei = 4'd0;
    apply(h);
    h.tag = 112;
    apply(h);
    h.tag = 113; h.rdy = 1; h.ei = 4'd1;
    apply(h);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter16.md
RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 The block SHALL have parameter N_REQ, default 16, meaning the number of requesters; only 16 is supported, matching the 4-bit index decoded to 16 one-hot lines.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 16 bits: per-requester request, bit i = requester i.
REQ-005 The block SHALL have port mask_we, input, 1 bit: write strobe for the enable mask.
REQ-006 The block SHALL have port mask_wdata, input, 16 bits: new enable mask value.
REQ-007 The block SHALL have port gnt_ready, input, 1 bit: the shared resource accepts the current grant.
REQ-008 The block SHALL have port gnt_valid, output, 1 bit: a grant is being offered.
REQ-009 The block SHALL have port gnt_idx, output, 4 bits: binary index of the granted requester.
REQ-010 The block SHALL have port gnt_onehot, output, 16 bits: one-hot decode of gnt_idx, qualified by gnt_valid.
REQ-011 The block SHALL have port mask, output, 16 bits: current enable mask.

Function
REQ-012 The block SHALL define eligible = req AND mask, evaluated every cycle.
REQ-013 The block SHALL implement two states: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
REQ-014 In IDLE with eligible nonzero, the block SHALL select the first eligible index at or after ptr, searching upward with wrap 15->0, register it into gnt_idx, and enter GRANT; gnt_valid rises exactly one cycle after req is sampled.
REQ-015 In IDLE with eligible zero, the block SHALL remain in IDLE, with gnt_idx and ptr unchanged.
REQ-016 In GRANT, gnt_idx SHALL stay stable until a handshake (gnt_valid AND gnt_ready); deasserting req or clearing the mask bit SHALL NOT revoke a grant.
REQ-017 On a handshake, ptr SHALL become (gnt_idx+1) mod 16, wrapping 15->0.
REQ-018 On a handshake, the block SHALL arbitrate in the same cycle using the new ptr and current eligible; if nonzero it SHALL stay in GRANT with the new gnt_idx, giving back-to-back grants with no bubble, otherwise it SHALL enter IDLE.
REQ-019 A requester that has just been served SHALL be lowest priority in the next arbitration; with all 16 requesting continuously, grants SHALL cycle 0,1,...,15,0.
REQ-020 When mask_we=1, mask SHALL load mask_wdata at the next edge; the new mask affects arbitrations from the following cycle onward.
REQ-021 gnt_onehot SHALL equal 1<<gnt_idx when gnt_valid=1, else 16'h0000.
REQ-022 gnt_ready while in IDLE SHALL be ignored.

Reset
REQ-023 When reset=1 at an edge, the block SHALL set state=IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, ptr=0 and mask=16'hFFFF, overriding any simultaneous handshake or mask write.
REQ-024 Reset asserted mid-grant SHALL drop the grant without a handshake; arbitration SHALL resume from ptr=0 on the first cycle after reset deasserts.

Structure
REQ-025 State encodings and the reset mask constant (16'hFFFF) SHALL live in a shared package/include used by the MIPS pipeline controllers.
REQ-026 The one-hot output SHALL be produced by instantiating the existing decoder4 4-to-16 decoder as the single sub-module, ANDed with gnt_valid.
REQ-027 The rotate-priority search SHALL be combinational logic inside rr_arbiter16; the registers SHALL be state, gnt_idx, ptr and mask only.

Verification
REQ-028 Bench SHALL drive reset=1 for 2 cycles -> gnt_valid=0, gnt_idx=0, gnt_onehot=0, mask=16'hFFFF.
REQ-029 Bench SHALL hold req=16'hFFFF and gnt_ready=1 for 18 cycles -> gnt_idx sequence 0..15,0 with gnt_valid continuously 1 after the first cycle, and gnt_onehot matching each index.
REQ-030 Bench SHALL set req=16'h8001, grant idx 15, then handshake -> next gnt_idx=0, confirming wrap.
REQ-031 Bench SHALL grant idx 3 with gnt_ready=0 for 5 cycles while req toggles to 16'h0010 -> gnt_idx stays 3 until gnt_ready=1, then becomes 4.
REQ-032 Bench SHALL write mask=16'hFFFE with req=16'h0003 -> only idx 1 is ever granted; then write mask=16'hFFFF -> idx 0 is granted after idx 1.
REQ-033 Bench SHALL assert reset during GRANT at idx 7 with req=16'hFFFF -> gnt_valid=0 next cycle, and the first grant after reset is idx 0.
